// File: rtl/character_motion_pkg.sv
// Shared types and constants for the character_motion block.
//   state_t      : motion FSM state encoding (3 bits)
//   RAMP_*       : codes carried on the ramp input
//   DEF_*_DIV    : default tick divider reload values (cycles per tick minus 1)
package character_motion_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWalk,
    StRise,
    StFall,
    StClimb,
    StLadderIdle
  } state_t;

  localparam logic [1:0] RAMP_FLAT = 2'b00;
  localparam logic [1:0] RAMP_UP_R = 2'b01;  // floor rises towards +x
  localparam logic [1:0] RAMP_UP_L = 2'b10;  // floor rises towards -x

  localparam logic [19:0] DEF_MOVE_DIV = 20'd400000;
  localparam logic [19:0] DEF_GRAV_DIV = 20'd800000;

endpackage

// File: rtl/character_motion_if.sv
// Key, map and sprite-position signals of one character_motion instance.
//   master : game/map side; drives keys and map knowledge, reads sprite state
//   slave  : character_motion; reads keys/map, drives xpos/ypos and status flags
interface character_motion_if #(
  parameter int unsigned X_W = 12,
  parameter int unsigned Y_W = 12
);

  logic           enable;
  logic           respawn;
  logic           left;
  logic           right;
  logic           jump;
  logic           up;
  logic           down;
  logic           ladder;
  logic [1:0]     ramp;
  logic           end_of_ramp;
  logic [Y_W-1:0] landing_ypos;
  logic [Y_W-1:0] ladder_ymin;
  logic [Y_W-1:0] ladder_ymax;
  logic [X_W-1:0] xpos;
  logic [Y_W-1:0] ypos;
  logic           airborne;
  logic           on_ladder;
  logic           facing_left;

  modport master (
    output enable, respawn, left, right, jump, up, down, ladder,
    output ramp, end_of_ramp, landing_ypos, ladder_ymin, ladder_ymax,
    input  xpos, ypos, airborne, on_ladder, facing_left
  );

  modport slave (
    input  enable, respawn, left, right, jump, up, down, ladder,
    input  ramp, end_of_ramp, landing_ypos, ladder_ymin, ladder_ymax,
    output xpos, ypos, airborne, on_ladder, facing_left
  );

endinterface

// File: rtl/character_motion_tick_gen.sv
// Movement and gravity tick generator for character_motion.
// Two free-running dividers; each emits a one-cycle pulse every DIV+1 cycles.
//   clk, rst     : clock, synchronous active-high reset
//   i_clear      : synchronous clear of both dividers (state change / respawn)
//   o_move_tick  : walk/climb step pulse
//   o_grav_tick  : gravity step pulse
module character_motion_tick_gen
  import character_motion_pkg::*;
#(
  parameter logic [19:0] MOVE_DIV = DEF_MOVE_DIV,
  parameter logic [19:0] GRAV_DIV = DEF_GRAV_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  output logic o_move_tick,
  output logic o_grav_tick
);

  logic [19:0] r_move_cnt;
  logic [19:0] r_grav_cnt;

  assign o_move_tick = (r_move_cnt == MOVE_DIV);
  assign o_grav_tick = (r_grav_cnt == GRAV_DIV);

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_move_cnt <= '0;
      r_grav_cnt <= '0;
    end else begin
      r_move_cnt <= o_move_tick ? '0 : r_move_cnt + 20'd1;
      r_grav_cnt <= o_grav_tick ? '0 : r_grav_cnt + 20'd1;
    end
  end

endmodule

// File: rtl/character_motion.sv
// Single-sprite motion controller: walk (with ramp following), ballistic jump,
// gravity fall and ladder climbing. Map knowledge arrives through the bus.
//   clk, rst : clock, synchronous active-high reset
//   bus      : character_motion_if.slave -- keys, map info in; xpos/ypos, airborne,
//              on_ladder, facing_left out (all registered state)
// Build option: define AIR_CONTROL_EN to let left/right steer the sprite while
// airborne; otherwise xpos is frozen during RISE/FALL.
module character_motion
  import character_motion_pkg::*;
#(
  parameter int unsigned X_W         = 12,
  parameter int unsigned Y_W         = 12,
  parameter logic [19:0] MOVE_DIV    = DEF_MOVE_DIV,
  parameter logic [19:0] GRAV_DIV    = DEF_GRAV_DIV,
  parameter int unsigned JUMP_V0     = 8,
  parameter int unsigned JUMP_HEIGHT = 48,
  parameter int unsigned MAX_FALL_V  = 12,
  parameter int unsigned CHAR_WIDTH  = 48,
  parameter int unsigned SCREEN_W    = 1024,
  parameter int unsigned X_MIN       = 1,
  parameter int unsigned RAMP_PERIOD = 64,
  parameter int unsigned RAMP_STEP   = 4,
  parameter int unsigned START_X     = 1,
  parameter int unsigned START_Y     = 672
) (
  input logic               clk,
  input logic               rst,
  character_motion_if.slave bus
);

  localparam logic [X_W-1:0] StartX    = X_W'(START_X);
  localparam logic [X_W-1:0] XMin      = X_W'(X_MIN);
  localparam logic [X_W-1:0] RampMask  = X_W'(RAMP_PERIOD - 1);
  localparam logic [X_W:0]   CharW     = (X_W+1)'(CHAR_WIDTH);
  localparam logic [X_W:0]   ScreenW   = (X_W+1)'(SCREEN_W);
  localparam logic [Y_W-1:0] StartY    = Y_W'(START_Y);
  localparam logic [Y_W-1:0] RampStepY = Y_W'(RAMP_STEP);
  localparam logic [Y_W:0]   JumpH     = (Y_W+1)'(JUMP_HEIGHT);
  localparam logic [7:0]     JumpV0    = 8'(JUMP_V0);
  localparam logic [7:0]     MaxFallV  = 8'(MAX_FALL_V);

  state_t         r_state,       w_state_d;
  logic [X_W-1:0] r_xpos,        w_xpos_d;
  logic [Y_W-1:0] r_ypos,        w_ypos_d;
  logic [7:0]     r_vel,         w_vel_d;
  logic [Y_W-1:0] r_floor,       w_floor_d;
  logic           r_dir_left,    w_dir_left_d;
  logic           r_climb_up,    w_climb_up_d;
  logic           r_facing_left, w_facing_left_d;

  logic w_move_tick, w_grav_tick, w_tick_clr;

  // Keys are only honoured while the game is running.
  logic w_left, w_right, w_jump, w_up, w_down;
  assign w_left  = bus.enable & bus.left;
  assign w_right = bus.enable & bus.right;
  assign w_jump  = bus.enable & bus.jump;
  assign w_up    = bus.enable & bus.up;
  assign w_down  = bus.enable & bus.down;

  // Horizontal step candidates with screen clamps.
  logic           w_at_left, w_at_right;
  logic [X_W-1:0] w_x_left, w_x_right;
  assign w_at_left  = (r_xpos <= XMin);
  assign w_at_right = (({1'b0, r_xpos} + CharW) >= ScreenW);
  assign w_x_left   = w_at_left  ? r_xpos : r_xpos - X_W'(1);
  assign w_x_right  = w_at_right ? r_xpos : r_xpos + X_W'(1);

  // Ramp adjust is decided on the pre-step x position.
  logic           w_ramp_edge;
  logic [Y_W-1:0] w_y_ramp_up, w_y_ramp_dn;
  assign w_ramp_edge = ((r_xpos & RampMask) == '0);
  assign w_y_ramp_up = (r_ypos >= RampStepY) ? r_ypos - RampStepY : '0;
  assign w_y_ramp_dn = r_ypos + RampStepY;

  // Jump/fall arithmetic at Y_W+1 bits so nothing wraps.
  logic [Y_W:0]   w_floor_ext, w_top_ext, w_vel_ext, w_fall_sum;
  logic           w_rise_clamp;
  logic [Y_W-1:0] w_fall_y;
  logic [7:0]     w_fall_vel;
  assign w_floor_ext  = {1'b0, r_floor};
  assign w_top_ext    = (w_floor_ext >= JumpH) ? w_floor_ext - JumpH : '0;
  assign w_vel_ext    = (Y_W+1)'(r_vel);
  assign w_rise_clamp = ({1'b0, r_ypos} <= (w_top_ext + w_vel_ext));
  assign w_fall_sum   = {1'b0, r_ypos} + w_vel_ext;
  assign w_fall_y     = (w_fall_sum >= w_floor_ext) ? r_floor : w_fall_sum[Y_W-1:0];
  assign w_fall_vel   = (r_vel >= MaxFallV) ? MaxFallV : r_vel + 8'd1;

  logic w_walk_key, w_climb_key, w_climb_limit;
  assign w_walk_key    = r_dir_left ? w_left : w_right;
  assign w_climb_key   = r_climb_up ? w_up : w_down;
  assign w_climb_limit = r_climb_up ? (r_ypos <= bus.ladder_ymin)
                                    : (r_ypos >= bus.ladder_ymax);

  always_comb begin
    w_state_d       = r_state;
    w_xpos_d        = r_xpos;
    w_ypos_d        = r_ypos;
    w_vel_d         = r_vel;
    w_floor_d       = r_floor;
    w_dir_left_d    = r_dir_left;
    w_climb_up_d    = r_climb_up;
    w_facing_left_d = r_facing_left;

    case (r_state)
      StIdle: begin
        if (bus.end_of_ramp) begin
          w_state_d = StFall;
          w_floor_d = bus.landing_ypos;
          w_vel_d   = '0;
        end else if (w_left) begin
          w_state_d       = StWalk;
          w_dir_left_d    = 1'b1;
          w_facing_left_d = 1'b1;
        end else if (w_right) begin
          w_state_d       = StWalk;
          w_dir_left_d    = 1'b0;
          w_facing_left_d = 1'b0;
        end else if (w_jump) begin
          w_state_d = StRise;
          w_floor_d = r_ypos;
          w_vel_d   = JumpV0;
        end else if (bus.ladder && w_up) begin
          w_state_d    = StClimb;
          w_climb_up_d = 1'b1;
        end else if (bus.ladder && w_down) begin
          w_state_d    = StClimb;
          w_climb_up_d = 1'b0;
        end
      end

      StWalk: begin
        if (w_move_tick) begin
          w_xpos_d = r_dir_left ? w_x_left : w_x_right;
          // Ramp follows the step direction even when x is held at a bound.
          if (w_ramp_edge) begin
            case (bus.ramp)
              RAMP_UP_R: w_ypos_d = r_dir_left ? w_y_ramp_dn : w_y_ramp_up;
              RAMP_UP_L: w_ypos_d = r_dir_left ? w_y_ramp_up : w_y_ramp_dn;
              RAMP_FLAT: ;
              default:   ;
            endcase
          end
          if (bus.end_of_ramp) begin
            w_state_d = StFall;
            w_floor_d = bus.landing_ypos;
            w_vel_d   = '0;
          end else if (!w_walk_key) begin
            w_state_d = StIdle;
          end
        end
      end

      StRise: begin
        if (w_grav_tick) begin
          if (w_rise_clamp || (r_vel == '0)) begin
            if (w_rise_clamp) w_ypos_d = w_top_ext[Y_W-1:0];
            w_vel_d   = '0;
            w_state_d = StFall;
          end else begin
            w_ypos_d = r_ypos - Y_W'(r_vel);
            w_vel_d  = r_vel - 8'd1;
          end
        end
      end

      StFall: begin
        if (w_grav_tick) begin
          w_ypos_d = w_fall_y;
          w_vel_d  = w_fall_vel;
          if (w_fall_y == r_floor) w_state_d = StIdle;
        end
      end

      StClimb: begin
        if (w_move_tick) begin
          if (w_climb_limit) begin
            w_state_d = StIdle;
          end else begin
            w_ypos_d = r_climb_up ? r_ypos - Y_W'(1) : r_ypos + Y_W'(1);
            if (!w_climb_key) w_state_d = StLadderIdle;
          end
        end
      end

      StLadderIdle: begin
        if (w_up) begin
          w_state_d    = StClimb;
          w_climb_up_d = 1'b1;
        end else if (w_down) begin
          w_state_d    = StClimb;
          w_climb_up_d = 1'b0;
        end
      end

      default: w_state_d = StIdle;
    endcase

`ifdef AIR_CONTROL_EN
    if (((r_state == StRise) || (r_state == StFall)) && w_move_tick) begin
      if (w_left) begin
        w_xpos_d        = w_x_left;
        w_facing_left_d = 1'b1;
      end else if (w_right) begin
        w_xpos_d        = w_x_right;
        w_facing_left_d = 1'b0;
      end
    end
`endif
  end

  // Dividers restart on every state change so the first step is a full period in.
  assign w_tick_clr = bus.respawn || (w_state_d != r_state);

  character_motion_tick_gen #(
    .MOVE_DIV (MOVE_DIV),
    .GRAV_DIV (GRAV_DIV)
  ) u_tick_gen (
    .clk         (clk),
    .rst         (rst),
    .i_clear     (w_tick_clr),
    .o_move_tick (w_move_tick),
    .o_grav_tick (w_grav_tick)
  );

  always_ff @(posedge clk) begin
    if (rst || bus.respawn) begin
      r_state       <= StIdle;
      r_xpos        <= StartX;
      r_ypos        <= StartY;
      r_vel         <= '0;
      r_floor       <= StartY;
      r_dir_left    <= 1'b0;
      r_climb_up    <= 1'b0;
      r_facing_left <= 1'b0;
    end else begin
      r_state       <= w_state_d;
      r_xpos        <= w_xpos_d;
      r_ypos        <= w_ypos_d;
      r_vel         <= w_vel_d;
      r_floor       <= w_floor_d;
      r_dir_left    <= w_dir_left_d;
      r_climb_up    <= w_climb_up_d;
      r_facing_left <= w_facing_left_d;
    end
  end

  assign bus.xpos        = r_xpos;
  assign bus.ypos        = r_ypos;
  assign bus.airborne    = (r_state == StRise) || (r_state == StFall);
  assign bus.on_ladder   = (r_state == StClimb) || (r_state == StLadderIdle);
  assign bus.facing_left = r_facing_left;

endmodule

// File: tb/tb_character_motion.sv
// Directed self-checking bench for character_motion (MOVE_DIV=3, GRAV_DIV=7).
// Inputs change 1 ns after a rising edge; outputs are sampled at the same point.
module tb_character_motion;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  character_motion_if #(.X_W(12), .Y_W(12)) bus ();

  character_motion #(
    .MOVE_DIV (20'd3),
    .GRAV_DIV (20'd7)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  int rise_exp [8] = '{664, 657, 651, 646, 642, 639, 637, 636};
  int fall_exp [9] = '{636, 637, 639, 642, 646, 651, 657, 664, 672};
  int eor_exp  [8] = '{672, 673, 675, 678, 682, 687, 693, 700};

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic respawn_pulse();
    bus.respawn = 1'b1;
    tick(1);
    bus.respawn = 1'b0;
  endtask

  initial begin
    bus.enable       = 1'b0;
    bus.respawn      = 1'b0;
    bus.left         = 1'b0;
    bus.right        = 1'b0;
    bus.jump         = 1'b0;
    bus.up           = 1'b0;
    bus.down         = 1'b0;
    bus.ladder       = 1'b0;
    bus.ramp         = 2'b00;
    bus.end_of_ramp  = 1'b0;
    bus.landing_ypos = 12'd700;
    bus.ladder_ymin  = 12'd660;
    bus.ladder_ymax  = 12'd700;

    // Reset state
    tick(2);
    check_eq("rst_xpos", bus.xpos, 1);
    check_eq("rst_ypos", bus.ypos, 672);
    check_eq("rst_airborne", bus.airborne, 0);
    check_eq("rst_on_ladder", bus.on_ladder, 0);
    check_eq("rst_facing", bus.facing_left, 0);
    rst = 1'b0;

    // Flat walk right
    bus.enable = 1'b1;
    bus.right  = 1'b1;
    tick(1);
    check_eq("walk_entry_x", bus.xpos, 1);
    tick(3);
    check_eq("walk_no_early_step", bus.xpos, 1);
    tick(1);
    check_eq("walk_first_step", bus.xpos, 2);
    tick(36);
    check_eq("walk_x_after_40", bus.xpos, 11);
    check_eq("walk_flat_y", bus.ypos, 672);
    bus.right = 1'b0;
    tick(4);
    check_eq("walk_release_step", bus.xpos, 12);

    // Jump: only taken from IDLE, so this also shows the walk ended
    bus.jump = 1'b1;
    tick(1);
    check_eq("jump_entry_airborne", bus.airborne, 1);
    check_eq("jump_entry_y", bus.ypos, 672);
    bus.jump  = 1'b0;
    bus.right = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick(8);
      check_eq($sformatf("rise_y%0d", k), bus.ypos, rise_exp[k]);
      check_eq($sformatf("rise_air%0d", k), bus.airborne, 1);
    end
    bus.right = 1'b0;
`ifdef AIR_CONTROL_EN
    check_eq("air_ctrl_x", bus.xpos, 28);
`else
    check_eq("air_frozen_x", bus.xpos, 12);
`endif
    tick(8);
    check_eq("apex_y", bus.ypos, 636);
    check_eq("apex_airborne", bus.airborne, 1);
    for (int k = 0; k < 9; k++) begin
      tick(8);
      check_eq($sformatf("fall_y%0d", k), bus.ypos, fall_exp[k]);
      check_eq($sformatf("fall_air%0d", k), bus.airborne, (k < 8) ? 1 : 0);
    end

    // Respawn mid-RISE
    bus.jump = 1'b1;
    tick(1);
    bus.jump = 1'b0;
    tick(16);
    check_eq("pre_respawn_y", bus.ypos, 657);
    respawn_pulse();
    check_eq("respawn_x", bus.xpos, 1);
    check_eq("respawn_y", bus.ypos, 672);
    check_eq("respawn_airborne", bus.airborne, 0);

    // Ramp rising to the right
    bus.ramp  = 2'b01;
    bus.right = 1'b1;
    tick(1);
    tick(252);
    check_eq("ramp_x64", bus.xpos, 64);
    check_eq("ramp_y_before64", bus.ypos, 672);
    tick(4);
    check_eq("ramp_x65", bus.xpos, 65);
    check_eq("ramp_y_step64", bus.ypos, 668);
    tick(252);
    check_eq("ramp_x128", bus.xpos, 128);
    check_eq("ramp_y_before128", bus.ypos, 668);
    tick(4);
    check_eq("ramp_x129", bus.xpos, 129);
    check_eq("ramp_y_step128", bus.ypos, 664);
    bus.right = 1'b0;
    bus.ramp  = 2'b00;
    tick(4);
    check_eq("ramp_release_x", bus.xpos, 130);

    // end_of_ramp with enable low
    respawn_pulse();
    bus.enable       = 1'b0;
    bus.landing_ypos = 12'd700;
    bus.end_of_ramp  = 1'b1;
    tick(1);
    bus.end_of_ramp  = 1'b0;
    check_eq("eor_airborne", bus.airborne, 1);
    for (int k = 0; k < 8; k++) begin
      tick(8);
      check_eq($sformatf("eor_y%0d", k), bus.ypos, eor_exp[k]);
      check_eq($sformatf("eor_air%0d", k), bus.airborne, (k < 7) ? 1 : 0);
    end

    // Long fall: velocity capped at 12
    bus.landing_ypos = 12'd800;
    bus.end_of_ramp  = 1'b1;
    tick(1);
    bus.end_of_ramp  = 1'b0;
    tick(8 * 13);
    check_eq("cap_y13", bus.ypos, 778);
    tick(8);
    check_eq("cap_y14", bus.ypos, 790);
    tick(8);
    check_eq("cap_land_y", bus.ypos, 800);
    check_eq("cap_land_air", bus.airborne, 0);

    // Ladder climb
    respawn_pulse();
    bus.enable = 1'b1;
    bus.ladder = 1'b1;
    bus.up     = 1'b1;
    tick(1);
    check_eq("climb_on_ladder", bus.on_ladder, 1);
    tick(48);
    check_eq("climb_y_top", bus.ypos, 660);
    check_eq("climb_top_on_ladder", bus.on_ladder, 1);
    tick(4);
    check_eq("climb_limit_idle", bus.on_ladder, 0);
    check_eq("climb_limit_y", bus.ypos, 660);
    bus.up   = 1'b0;
    bus.down = 1'b1;
    tick(1);
    check_eq("climb_down_on", bus.on_ladder, 1);
    tick(8);
    check_eq("climb_down_y", bus.ypos, 662);
    bus.down = 1'b0;
    tick(4);
    check_eq("ladder_idle_y", bus.ypos, 663);
    check_eq("ladder_idle_on", bus.on_ladder, 1);
    bus.left = 1'b1;
    bus.jump = 1'b1;
    tick(8);
    check_eq("ladder_idle_hold_x", bus.xpos, 1);
    check_eq("ladder_idle_hold_y", bus.ypos, 663);
    check_eq("ladder_idle_no_jump", bus.airborne, 0);
    check_eq("ladder_idle_still_on", bus.on_ladder, 1);
    bus.left = 1'b0;
    bus.jump = 1'b0;
    bus.up   = 1'b1;
    tick(1);
    tick(4);
    check_eq("ladder_resume_up_y", bus.ypos, 662);
    bus.up     = 1'b0;
    bus.ladder = 1'b0;

    // Facing and left clamp; left+right resolves to left
    respawn_pulse();
    bus.left  = 1'b1;
    bus.right = 1'b1;
    tick(1);
    check_eq("both_keys_facing_left", bus.facing_left, 1);
    tick(4);
    check_eq("left_clamp_x", bus.xpos, 1);
    bus.left  = 1'b0;
    bus.right = 1'b0;
    tick(4);
    bus.right = 1'b1;
    tick(1);
    check_eq("facing_right_again", bus.facing_left, 0);
    bus.right = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
    $finish;
  end

endmodule
